// File: rtl/st_block_filter_if.sv
// Store-path handshake bundle for st_block_filter: input streams, DDR write
// streams, tile control and status.
interface st_block_filter_if #(
  parameter int ADDR_WIDTH = 42,
  parameter int DATA_WIDTH = 64,
  parameter int CNT_W      = 32
);
  logic                  cfg_block_padding_v;
  logic                  in_addr_valid;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic                  in_addr_ready;
  logic                  block_mask;
  logic                  in_data_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_data_ready;
  logic                  block_data;
  logic                  all_done;
  logic                  out_addr_valid;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_addr_ready;
  logic                  out_data_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_data_ready;
  logic [CNT_W-1:0]      drop_addr_cnt;
  logic [CNT_W-1:0]      drop_data_cnt;
  logic                  done;
  logic                  err;

  modport master (
    output cfg_block_padding_v, in_addr_valid, in_addr, block_mask,
           in_data_valid, in_data, block_data, all_done,
           out_addr_ready, out_data_ready,
    input  in_addr_ready, in_data_ready, out_addr_valid, out_addr,
           out_data_valid, out_data, drop_addr_cnt, drop_data_cnt, done, err
  );

  modport slave (
    input  cfg_block_padding_v, in_addr_valid, in_addr, block_mask,
           in_data_valid, in_data, block_data, all_done,
           out_addr_ready, out_data_ready,
    output in_addr_ready, in_data_ready, out_addr_valid, out_addr,
           out_data_valid, out_data, drop_addr_cnt, drop_data_cnt, done, err
  );
endinterface

// File: rtl/st_block_filter.sv
// Store-path block filter: drops masked addr/data beats, forwards the rest through
// 2-entry skid buffers, counts drops and reports tile completion.
module st_block_filter_chan #(
  parameter int W     = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_valid,
  input  logic [W-1:0]     i_data,
  input  logic             i_drop,
  output logic             o_ready,
  output logic             o_valid,
  output logic [W-1:0]     o_data,
  input  logic             i_ready,
  output logic [CNT_W-1:0] o_drop_cnt,
  output logic [CNT_W-1:0] o_fwd_cnt,
  output logic             o_empty
);
  logic             r_rdy;
  logic             r_out_v;
  logic             r_skid_v;
  logic [W-1:0]     r_out_d;
  logic [W-1:0]     r_skid_d;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] r_fwd_cnt;
  logic             w_acc;
  logic             w_push;
  logic             w_pop;
  logic             w_load;
  logic             w_skid_v_nxt;

  assign w_acc        = i_valid & r_rdy;
  assign w_push       = w_acc & ~i_drop;
  assign w_pop        = r_out_v & i_ready;
  assign w_load       = w_pop | ~r_out_v;
  // skid only fills when the output reg is held and a new beat arrives
  assign w_skid_v_nxt = w_load ? 1'b0 : (r_skid_v | w_push);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdy      <= 1'b0;
      r_out_v    <= 1'b0;
      r_skid_v   <= 1'b0;
      r_out_d    <= '0;
      r_skid_d   <= '0;
      r_drop_cnt <= '0;
      r_fwd_cnt  <= '0;
    end else begin
      r_rdy <= ~w_skid_v_nxt;
      if (w_load) begin
        if (r_skid_v) begin
          r_out_v <= 1'b1;
          r_out_d <= r_skid_d;
        end else begin
          r_out_v <= w_push;
          if (w_push) r_out_d <= i_data;
        end
        r_skid_v <= 1'b0;
      end else if (w_push) begin
        r_skid_v <= 1'b1;
        r_skid_d <= i_data;
      end
      if (i_clr) begin
        r_drop_cnt <= '0;
        r_fwd_cnt  <= '0;
      end else begin
        if (w_acc && i_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        if (w_pop && (r_fwd_cnt != '1)) r_fwd_cnt <= r_fwd_cnt + CNT_W'(1);
      end
    end
  end

  assign o_ready    = r_rdy;
  assign o_valid    = r_out_v;
  assign o_data     = r_out_d;
  assign o_drop_cnt = r_drop_cnt;
  assign o_fwd_cnt  = r_fwd_cnt;
  assign o_empty    = ~(r_out_v | r_skid_v);
endmodule

module st_block_filter #(
  parameter int ADDR_WIDTH = 42,
  parameter int DATA_WIDTH = 64,
  parameter int CNT_W      = 32
) (
  input logic          clk,
  input logic          reset,
  st_block_filter_if.slave bus
);
  // IDLE: no tile | RUN: tile active | DRAIN: waiting for empty | DONE: done pulse
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  logic             r_done;
  logic             r_err;
  logic [CNT_W-1:0] w_fwd_a;
  logic [CNT_W-1:0] w_fwd_d;
  logic             w_empty_a;
  logic             w_empty_d;

  st_block_filter_chan #(.W(ADDR_WIDTH), .CNT_W(CNT_W)) u_addr (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (bus.cfg_block_padding_v),
    .i_valid    (bus.in_addr_valid),
    .i_data     (bus.in_addr),
    .i_drop     (bus.block_mask),
    .o_ready    (bus.in_addr_ready),
    .o_valid    (bus.out_addr_valid),
    .o_data     (bus.out_addr),
    .i_ready    (bus.out_addr_ready),
    .o_drop_cnt (bus.drop_addr_cnt),
    .o_fwd_cnt  (w_fwd_a),
    .o_empty    (w_empty_a)
  );

  st_block_filter_chan #(.W(DATA_WIDTH), .CNT_W(CNT_W)) u_data (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (bus.cfg_block_padding_v),
    .i_valid    (bus.in_data_valid),
    .i_data     (bus.in_data),
    .i_drop     (bus.block_data),
    .o_ready    (bus.in_data_ready),
    .o_valid    (bus.out_data_valid),
    .o_data     (bus.out_data),
    .i_ready    (bus.out_data_ready),
    .o_drop_cnt (bus.drop_data_cnt),
    .o_fwd_cnt  (w_fwd_d),
    .o_empty    (w_empty_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.cfg_block_padding_v) begin
        r_state <= S_RUN;
        r_err   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: ;
          S_RUN: if (bus.all_done) r_state <= S_DRAIN;
          S_DRAIN: if (w_empty_a && w_empty_d) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_err   <= r_err | (w_fwd_a != w_fwd_d);
          end
          S_DONE: r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.done = r_done;
  assign bus.err  = r_err;
endmodule
